// File: rtl/serial_parity_framer.sv
// -----------------------------------------------------------------------------
// serial_parity_framer
//
// Assembles a 1-bit serial stream into 3-bit frames {A,B,C}, registers each
// completed frame together with its even-parity flag f, and counts frames
// that complete with odd parity (f=0) in a saturating counter. A partial
// frame that stalls for TIMEOUT idle cycles is discarded and flagged.
//
// Parameters:
//   CNT_W    width of the saturating odd-parity frame counter
//   TIMEOUT  idle cycles tolerated mid-frame before the partial frame drops
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din_valid    din carries a bit this cycle
//   din          serial bit; frame order is A, then B, then C
//   clr_cnt      synchronous clear of err_cnt (wins over a same-cycle count)
//   A, B, C      last completed frame, held until the next one completes
//   f            1 when {A,B,C} holds an even number of ones
//   frame_valid  one-cycle pulse: A/B/C/f just updated
//   abort        one-cycle pulse: partial frame discarded by timeout
//   err_cnt      number of completed frames with f=0, saturating
// -----------------------------------------------------------------------------
module serial_parity_framer #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             f,
    output logic             frame_valid,
    output logic             abort,
    output logic [CNT_W-1:0] err_cnt
);

    // Gap counter only has to reach TIMEOUT-1.
    localparam int GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S0 = 2'd0,   // expecting A
        S1 = 2'd1,   // expecting B
        S2 = 2'd2    // expecting C
    } state_t;

    // Even parity (XNOR of three bits): 1 for zero or two ones.
    function automatic logic parity_even(input logic a, input logic b, input logic c);
        return ~(a ^ b ^ c);
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_s;
    logic               sha_r;
    logic               sha_s;
    logic               shb_r;
    logic               shb_s;
    logic               a_r;
    logic               b_r;
    logic               c_r;
    logic               f_r;
    logic               a_s;
    logic               b_s;
    logic               c_s;
    logic               f_s;
    logic               frame_valid_r;
    logic               frame_valid_s;
    logic               abort_r;
    logic               abort_s;
    logic [CNT_W-1:0]   err_cnt_r;
    logic [CNT_W-1:0]   err_cnt_s;
    logic               timeout_hit_s;

    assign timeout_hit_s = (gap_cnt_r == GAP_W'(TIMEOUT - 1));

    // Next-state, shadow capture, frame load and timeout decisions.
    always_comb begin
        state_s       = state_r;
        gap_cnt_s     = gap_cnt_r;
        sha_s         = sha_r;
        shb_s         = shb_r;
        a_s           = a_r;
        b_s           = b_r;
        c_s           = c_r;
        f_s           = f_r;
        frame_valid_s = 1'b0;
        abort_s       = 1'b0;
        case (state_r)
            S0: begin
                gap_cnt_s = {GAP_W{1'b0}};
                if (din_valid) begin
                    sha_s   = din;
                    state_s = S1;
                end else begin
                    state_s = S0;
                end
            end
            S1, S2: begin
                if (din_valid) begin
                    // An arriving bit always beats a timeout on the same cycle.
                    gap_cnt_s = {GAP_W{1'b0}};
                    if (state_r == S1) begin
                        shb_s   = din;
                        state_s = S2;
                    end else begin
                        a_s           = sha_r;
                        b_s           = shb_r;
                        c_s           = din;
                        f_s           = parity_even(sha_r, shb_r, din);
                        frame_valid_s = 1'b1;
                        state_s       = S0;
                    end
                end else if (timeout_hit_s) begin
                    gap_cnt_s = {GAP_W{1'b0}};
                    sha_s     = 1'b0;
                    shb_s     = 1'b0;
                    abort_s   = 1'b1;
                    state_s   = S0;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_W'(1);
                end
            end
            default: begin
                gap_cnt_s = {GAP_W{1'b0}};
                sha_s     = 1'b0;
                shb_s     = 1'b0;
                state_s   = S0;
            end
        endcase
    end

    // Odd-parity counter: clear wins, otherwise count completed odd frames up to max.
    always_comb begin
        err_cnt_s = err_cnt_r;
        if (clr_cnt) begin
            err_cnt_s = {CNT_W{1'b0}};
        end else if (frame_valid_s && !f_s && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_s = err_cnt_r + CNT_W'(1);
        end else begin
            err_cnt_s = err_cnt_r;
        end
    end

    // State, shadow and gap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S0;
            gap_cnt_r <= {GAP_W{1'b0}};
            sha_r     <= 1'b0;
            shb_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            gap_cnt_r <= gap_cnt_s;
            sha_r     <= sha_s;
            shb_r     <= shb_s;
        end
    end

    // Registered outputs: frame, parity flag, pulses and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r           <= 1'b0;
            b_r           <= 1'b0;
            c_r           <= 1'b0;
            f_r           <= 1'b1;
            frame_valid_r <= 1'b0;
            abort_r       <= 1'b0;
            err_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            a_r           <= a_s;
            b_r           <= b_s;
            c_r           <= c_s;
            f_r           <= f_s;
            frame_valid_r <= frame_valid_s;
            abort_r       <= abort_s;
            err_cnt_r     <= err_cnt_s;
        end
    end

    assign A           = a_r;
    assign B           = b_r;
    assign C           = c_r;
    assign f           = f_r;
    assign frame_valid = frame_valid_r;
    assign abort       = abort_r;
    assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_serial_parity_framer.sv
// -----------------------------------------------------------------------------
// tb_serial_parity_framer
//
// Directed stimulus drives two framers in parallel (default CNT_W=8 and a
// CNT_W=2 copy for saturation). Every bit issued updates a small reference
// model; completed frames and timeouts push an expected event (kind, edge
// number, ABC, f, both counters) into a queue. A monitor pops and compares
// whenever frame_valid or abort is seen.
// -----------------------------------------------------------------------------
module tb_serial_parity_framer;

    localparam int TIMEOUT = 15;

    typedef struct {
        bit       is_frame;
        int       cyc;
        bit [2:0] abc;
        bit       f;
        int       err8;
        int       err2;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       din_valid;
    logic       din;
    logic       clr_cnt;
    logic       a8, b8, c8, f8, fv8, ab8;
    logic [7:0] err8;
    logic       a2, b2, c2, f2, fv2, ab2;
    logic [1:0] err2;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sbq[$];

    // Reference model state
    int       m_pos  = 0;
    int       m_gap  = 0;
    bit       m_sa, m_sb;
    bit [2:0] m_abc  = 3'b000;
    bit       m_f    = 1'b1;
    int       m_err8 = 0;
    int       m_err2 = 0;

    serial_parity_framer #(.CNT_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .A(a8), .B(b8), .C(c8), .f(f8), .frame_valid(fv8), .abort(ab8), .err_cnt(err8)
    );

    serial_parity_framer #(.CNT_W(2), .TIMEOUT(TIMEOUT)) dut2 (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .A(a2), .B(b2), .C(c2), .f(f2), .frame_valid(fv2), .abort(ab2), .err_cnt(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of input and advance the reference model.
    task automatic drive(input bit v, input bit d, input bit clr);
        exp_t e;
        bit   done;
        @(negedge clk);
        din_valid = v;
        din       = d;
        clr_cnt   = clr;
        done      = 1'b0;
        if (v) begin
            m_gap = 0;
            if (m_pos == 0) begin
                m_sa  = d;
                m_pos = 1;
            end else if (m_pos == 1) begin
                m_sb  = d;
                m_pos = 2;
            end else begin
                m_abc = {m_sa, m_sb, d};
                m_f   = ~(m_sa ^ m_sb ^ d);
                m_pos = 0;
                done  = 1'b1;
                if (!m_f) begin
                    if (m_err8 < 255) m_err8++;
                    if (m_err2 < 3)   m_err2++;
                end
            end
        end else if (m_pos != 0) begin
            if (m_gap == TIMEOUT - 1) begin
                m_pos = 0;
                m_gap = 0;
                e = '{is_frame: 1'b0, cyc: cyc + 1, abc: m_abc, f: m_f, err8: 0, err2: 0};
                if (clr) begin m_err8 = 0; m_err2 = 0; end
                e.err8 = m_err8;
                e.err2 = m_err2;
                sbq.push_back(e);
            end else begin
                m_gap++;
            end
        end
        if (clr) begin
            m_err8 = 0;
            m_err2 = 0;
        end
        if (done) begin
            e = '{is_frame: 1'b1, cyc: cyc + 1, abc: m_abc, f: m_f, err8: m_err8, err2: m_err2};
            sbq.push_back(e);
        end
    endtask

    task automatic bits(input bit [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b1, v[i], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_abc"},  int'({a8, b8, c8}), 0);
        chk({tag, "_f"},    int'(f8), 1);
        chk({tag, "_fv"},   int'(fv8), 0);
        chk({tag, "_abort"}, int'(ab8), 0);
        chk({tag, "_err8"}, int'(err8), 0);
        chk({tag, "_err2"}, int'(err2), 0);
    endtask

    // Monitor: every frame_valid/abort pulse must match the next expected event.
    always @(negedge clk) begin
        exp_t e;
        if (fv8 || ab8) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", int'({fv8, ab8}), 0);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind", int'({fv8, ab8}), e.is_frame ? 2 : 1);
                chk("pulse_cycle", cyc, e.cyc);
                chk("abc", int'({a8, b8, c8}), int'(e.abc));
                chk("f", int'(f8), int'(e.f));
                chk("err_cnt", int'(err8), e.err8);
                chk("err_cnt_w2", int'(err2), e.err2);
                chk("pulse_kind_w2", int'({fv2, ab2}), e.is_frame ? 2 : 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        clr_cnt   = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Even-parity frames back to back: 000, 011, 101, 110
        bits(16'b0000_1110_1110, 12);
        idle(3);

        // Odd frames 001 and 111
        bits(16'b001_111, 6);
        idle(3);

        // Timeout after two bits, then a normal frame 110
        bits(16'b10, 2);
        idle(15);
        idle(2);
        bits(16'b110, 3);
        idle(3);

        // Third bit lands exactly when the timeout would fire
        bits(16'b01, 2);
        idle(14);
        bits(16'b1, 1);
        idle(3);

        // Saturation of the narrow counter: clear, then five odd frames
        drive(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) bits(16'b111, 3);
        // Clear coincident with an odd frame: that frame is not counted
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        idle(2);
        chk("clr_priority_err8", int'(err8), 0);
        chk("clr_priority_err2", int'(err2), 0);

        // Asynchronous reset in the middle of a frame
        bits(16'b111, 3);
        bits(16'b10, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        m_pos = 0; m_gap = 0; m_abc = 3'b000; m_f = 1'b1; m_err8 = 0; m_err2 = 0;
        din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bits(16'b100, 3);
        idle(4);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
